alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_mul.sv | 49 ++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op codes, op width and FSM state type for alu_seq
package alu_seq_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_PASS = 4'd2,
    OP_ZER  = 4'd3,
    OP_DECA = 4'd4,
    OP_MUL2 = 4'd5,
    OP_DIV2 = 4'd6,
    OP_SHLN = 4'd7,
    OP_SHRN = 4'd8,
    OP_MUL  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, WIDTH steps per product
// done flags the final step; prod is the product as it will stand after that edge.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  assign done = (cnt_q == CW'(1));
  assign prod = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake and iterative shifts
// Optional multiply (op 9) is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] b_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_bus,
  output logic             z,
  output logic             cy,
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] c_q;
  logic             z_q, cy_q, err_q;
  logic [WIDTH-1:0] sh_q;
  logic [SHW-1:0]   cnt_q;
  logic             left_q;

  logic             accept;
  logic [WIDTH-1:0] r_c;
  logic             r_cy, r_err;
  logic             dec_busy, dec_left;
  logic [SHW-1:0]   k;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign c_bus     = c_q;
  assign z         = z_q;
  assign cy        = cy_q;
  assign err       = err_q;
  assign k         = b_bus[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
  logic               dec_mul, mul_q, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && dec_mul),
    .a     (a_bus),
    .b     (b_bus),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  // One-cycle results; ops needing BUSY only raise dec_busy here.
  always_comb begin
    r_c      = '0;
    r_cy     = 1'b0;
    r_err    = 1'b0;
    dec_busy = 1'b0;
    dec_left = 1'b0;
    wide     = '0;
`ifdef ALU_SEQ_MUL_EN
    dec_mul  = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        wide = {1'b0, a_bus} + {1'b0, b_bus};
        r_c  = wide[WIDTH-1:0];
        r_cy = wide[WIDTH];
      end
      OP_SUB: begin
        wide = {1'b0, a_bus} - {1'b0, b_bus};
        r_c  = wide[WIDTH-1:0];
        r_cy = wide[WIDTH];
      end
      OP_PASS: r_c = b_bus;
      OP_ZER:  r_c = '0;
      OP_DECA: begin
        r_c  = a_bus - WIDTH'(1);
        r_cy = (a_bus == '0);
      end
      OP_MUL2: begin
        r_c  = b_bus << 1;
        r_cy = b_bus[WIDTH-1];
      end
      OP_DIV2: begin
        r_c  = b_bus >> 1;
        r_cy = b_bus[0];
      end
      OP_SHLN, OP_SHRN: begin
        r_c      = a_bus;
        dec_busy = (k != '0);
        dec_left = (op == OP_SHLN);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        dec_busy = 1'b1;
        dec_mul  = 1'b1;
      end
`endif
      default: r_err = 1'b1;
    endcase
  end

  always_comb begin
    sh_next = left_q ? (sh_q << 1) : (sh_q >> 1);
    sh_out  = left_q ? sh_q[WIDTH-1] : sh_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      z_q     <= 1'b0;
      cy_q    <= 1'b0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_q   <= 1'b0;
`endif
    end else if (accept) begin
      sh_q   <= a_bus;
      cnt_q  <= k;
      left_q <= dec_left;
`ifdef ALU_SEQ_MUL_EN
      mul_q  <= dec_mul;
`endif
      if (dec_busy) begin
        state_q <= BUSY;
      end else begin
        state_q <= DONE;
        c_q     <= r_c;
        z_q     <= (r_c == '0);
        cy_q    <= r_cy;
        err_q   <= r_err;
      end
    end else begin
      case (state_q)
        BUSY: begin
`ifdef ALU_SEQ_MUL_EN
          if (mul_q) begin
            if (mul_done) begin
              state_q <= DONE;
              c_q     <= mul_prod[WIDTH-1:0];
              z_q     <= (mul_prod[WIDTH-1:0] == '0);
              cy_q    <= |mul_prod[2*WIDTH-1:WIDTH];
              err_q   <= 1'b0;
            end
          end else
`endif
          begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
              state_q <= DONE;
              c_q     <= sh_next;
              z_q     <= (sh_next == '0);
              cy_q    <= sh_out;
              err_q   <= 1'b0;
            end
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
